uart_colour_rx: RTL and testbench

//  UART 8N1 receiver feeding the WS2812 driver: each received byte becomes one 8-bit

---
 rtl/uart_colour_rx.sv | 129 ++++++++++++
 tb/tb_uart_colour_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_colour_rx.sv
// rtl/uart_colour_rx.sv - UART 8N1 receiver delivering colour bytes to the WS2812 driver
// A one-deep holding register lets a byte wait for the driver while the next one arrives.
module uart_colour_rx #(
  parameter int CLKS_PER_BIT = 1154
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       i_Rx,
  input  logic       i_Ready,
  output logic       o_Start,
  output logic [7:0] o_Colour,
  output logic       o_FrameErr,
  output logic       o_Overrun,
  output logic       o_Busy
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rx_m;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [7:0]  hold_reg;
  logic        pending;
  logic        half_hit;
  logic        full_hit;
  logic        byte_ok;
  logic        frame_bad;
  logic        busy;
  logic        consume;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_Rx;
      rx_s <= rx_m;
    end
  end

  assign half_hit = (cnt == HALF_M1);
  assign full_hit = (cnt == FULL_M1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rx_s) state_nxt = S_START;
      S_START: if (half_hit) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (full_hit && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (full_hit) state_nxt = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    byte_ok   = (state == S_STOP) && full_hit && rx_s;
    frame_bad = (state == S_STOP) && full_hit && !rx_s;
  end

  assign o_Busy = busy;

  // Bit timer restarts on each start edge so drift never accumulates across frames.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      case (state)
        S_START: cnt <= half_hit ? 16'd0 : cnt + 16'd1;
        S_DATA: begin
          if (full_hit) begin
            cnt     <= 16'd0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_STOP:  cnt <= full_hit ? 16'd0 : cnt + 16'd1;
        default: begin
          cnt     <= 16'd0;
          bit_idx <= 3'd0;
        end
      endcase
    end
  end

  assign consume = pending && i_Ready && !o_Start;

  // A byte arriving while the old one is handed off replaces it without overrun.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hold_reg   <= 8'h00;
      pending    <= 1'b0;
      o_Start    <= 1'b0;
      o_Colour   <= 8'h00;
      o_FrameErr <= 1'b0;
      o_Overrun  <= 1'b0;
    end else begin
      o_Start    <= consume;
      o_FrameErr <= frame_bad;
      if (consume) o_Colour <= hold_reg;
      if (byte_ok && pending && !consume) begin
        o_Overrun <= 1'b1;
      end else if (byte_ok) begin
        hold_reg <= shift;
        pending  <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_colour_rx.sv
// tb/tb_uart_colour_rx.sv - directed self-checking bench for uart_colour_rx
module tb_uart_colour_rx;
  localparam int CPB = 16;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       i_Rx;
  logic       i_Ready;
  logic       o_Start;
  logic [7:0] o_Colour;
  logic       o_FrameErr;
  logic       o_Overrun;
  logic       o_Busy;

  int errors = 0;
  int checks = 0;
  int n_start = 0;
  int n_fe = 0;
  int n_busy = 0;
  int n_dbl = 0;
  logic prev_start = 1'b0;
  logic [7:0] last_colour = 8'h00;

  uart_colour_rx #(.CLKS_PER_BIT(CPB)) dut (
    .Clock(Clock), .Reset(Reset), .i_Rx(i_Rx), .i_Ready(i_Ready),
    .o_Start(o_Start), .o_Colour(o_Colour), .o_FrameErr(o_FrameErr),
    .o_Overrun(o_Overrun), .o_Busy(o_Busy)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (o_Start) begin
      n_start++;
      last_colour = o_Colour;
    end
    if (prev_start && o_Start) n_dbl++;
    prev_start = o_Start;
    if (o_FrameErr) n_fe++;
    if (o_Busy) n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic drive_bit(input logic v);
    i_Rx = v;
    cycles(CPB);
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
  endtask

  int s0, f0, b0;
  logic seen;

  initial begin
    Reset = 1'b1; i_Rx = 1'b1; i_Ready = 1'b0;
    cycles(3);
    check("rst_start", 32'(o_Start), 0);
    check("rst_colour", 32'(o_Colour), 0);
    check("rst_ferr", 32'(o_FrameErr), 0);
    check("rst_overrun", 32'(o_Overrun), 0);
    check("rst_busy", 32'(o_Busy), 0);
    Reset = 1'b0;
    cycles(5);

    // basic byte with driver ready
    i_Ready = 1'b1;
    s0 = n_start; f0 = n_fe;
    send_byte(8'hA5);
    cycles(6);
    check("a5_starts", 32'(n_start - s0), 1);
    check("a5_colour", 32'(o_Colour), 32'h A5);
    check("a5_ferr", 32'(n_fe - f0), 0);
    check("a5_overrun", 32'(o_Overrun), 0);

    // driver busy: byte held
    i_Ready = 1'b0;
    s0 = n_start;
    send_byte(8'h3C);
    cycles(20);
    check("3c_held", 32'(n_start - s0), 0);
    check("3c_colour_old", 32'(o_Colour), 32'h A5);
    i_Ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clock);
      if (o_Start) seen = 1'b1;
    end
    check("3c_start_2cyc", 32'(seen), 1);
    check("3c_colour", 32'(o_Colour), 32'h 3C);
    cycles(4);
    check("3c_single", 32'(n_start - s0), 1);

    // overrun
    i_Ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    cycles(4);
    check("ovr_flag", 32'(o_Overrun), 1);
    s0 = n_start;
    i_Ready = 1'b1;
    cycles(10);
    check("ovr_starts", 32'(n_start - s0), 1);
    check("ovr_colour", 32'(last_colour), 32'h 11);
    check("ovr_sticky", 32'(o_Overrun), 1);

    // short glitch
    s0 = n_start; b0 = n_busy; f0 = n_fe;
    i_Rx = 1'b0;
    cycles(6);
    i_Rx = 1'b1;
    cycles(20);
    check("gl_starts", 32'(n_start - s0), 0);
    check("gl_busy_cycles", 32'(n_busy - b0), 8);
    check("gl_idle", 32'(o_Busy), 0);
    check("gl_ferr", 32'(n_fe - f0), 0);

    // framing error with held-low line
    s0 = n_start; f0 = n_fe;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h55 >> i));
    i_Rx = 1'b0;
    cycles(CPB + 30);
    check("fe_break_busy", 32'(o_Busy), 1);
    cycles(10);
    check("fe_pulses", 32'(n_fe - f0), 1);
    check("fe_starts", 32'(n_start - s0), 0);
    i_Rx = 1'b1;
    cycles(5);
    check("fe_idle", 32'(o_Busy), 0);
    s0 = n_start;
    send_byte(8'h0F);
    cycles(6);
    check("0f_starts", 32'(n_start - s0), 1);
    check("0f_colour", 32'(o_Colour), 32'h 0F);

    // reset during data bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hFF >> i));
    i_Rx = 1'b1;
    cycles(8);
    check("mid_busy", 32'(o_Busy), 1);
    Reset = 1'b1;
    #1;
    check("mr_start", 32'(o_Start), 0);
    check("mr_colour", 32'(o_Colour), 0);
    check("mr_ferr", 32'(o_FrameErr), 0);
    check("mr_overrun", 32'(o_Overrun), 0);
    check("mr_busy", 32'(o_Busy), 0);
    cycles(2);
    Reset = 1'b0;
    s0 = n_start;
    cycles(CPB * 6);
    check("mr_no_start", 32'(n_start - s0), 0);
    send_byte(8'hFF);
    cycles(6);
    check("ff_starts", 32'(n_start - s0), 1);
    check("ff_colour", 32'(o_Colour), 32'h FF);
    check("no_double_start", 32'(n_dbl), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
